// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war CPU opponent logic.
package tow_pkg;

    // Scheduler states for the computer player.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PRESS   = 2'd2,
        HOLDOFF = 2'd3
    } cpu_state_t;

    // Width of the pseudo-random generator; its taps are fixed for this width.
    localparam int LFSR_W = 10;

endpackage

// File: rtl/lfsr10.sv
// 10-bit XNOR LFSR (taps 9,6) that free-runs whenever reset is released.
// Starting from zero, it walks the 1023 non-lock-up states.
// The all-ones lock-up state is steered back to zero.
module lfsr10
    import tow_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    // Shift left with XNOR feedback; all-ones would stick forever, so map it to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (&q) begin
            q <= '0;
        end else begin
            q <= {q[LFSR_W-2:0], ~(q[LFSR_W-1] ^ q[6])};
        end
    end

endmodule

// File: rtl/cpu_press_scheduler.sv
// Computer-opponent press scheduler.
// On each tick while armed, the LFSR value is compared with the difficulty.
// A hit issues a single registered press pulse.
// A fixed hold-off window then follows before the scheduler re-arms.
module cpu_press_scheduler
    import tow_pkg::*;
#(
    parameter int W              = 10,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             game_over,
    input  logic             tick,
    input  logic [W-1:0]     difficulty,
    output logic             press,
    output logic             busy,
    output logic [W-1:0]     rand_q,
    output logic [CNT_W-1:0] press_count
);

    localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

    cpu_state_t        state;
    cpu_state_t        next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] next_hold;
    logic              hit;

    lfsr10 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (rand_q)
    );

    assign hit = tick && (rand_q < difficulty);

    // Next-state and hold-counter logic; disable or game over always wins.
    always_comb begin
        next_state = state;
        next_hold  = hold_cnt;
        if (!enable || game_over) begin
            next_state = IDLE;
            next_hold  = '0;
        end else begin
            case (state)
                IDLE:    next_state = ARMED;
                ARMED:   if (hit) next_state = PRESS;
                PRESS: begin
                    next_state = HOLDOFF;
                    next_hold  = HOLD_LOAD;
                end
                HOLDOFF: begin
                    if (hold_cnt == '0) begin
                        next_state = ARMED;
                    end else begin
                        next_hold = hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_hold  = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs; outputs are decoded from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            press       <= 1'b0;
            busy        <= 1'b0;
            press_count <= '0;
        end else begin
            state    <= next_state;
            hold_cnt <= next_hold;
            press    <= (next_state == PRESS);
            busy     <= (next_state == PRESS) || (next_state == HOLDOFF);
            if ((next_state == PRESS) && (state != PRESS) && !(&press_count)) begin
                press_count <= press_count + CNT_W'(1);
            end
        end
    end

endmodule
